// File: rtl/axis_fir_prog.sv
// AXI-Stream direct-form FIR with double-banked programmable coefficients, packet-aware history and output skid.
// Optional AXIS_FIR_PROG_SAT_EN: saturate (instead of wrap) when DATA_OUT_WIDTH < ACC_WIDTH.
module axis_fir_prog #(
    parameter int NUM_TAPS       = 8,
    parameter int TAP_WIDTH      = 8,
    parameter int DATA_IN_WIDTH  = 8,
    parameter int ACC_WIDTH      = TAP_WIDTH + DATA_IN_WIDTH + $clog2(NUM_TAPS),
    parameter int DATA_OUT_WIDTH = ACC_WIDTH,
    parameter int ADDR_WIDTH     = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic signed [DATA_IN_WIDTH-1:0]  s_axis_tdata,
    input  logic                             s_axis_tvalid,
    input  logic                             s_axis_tlast,
    output logic                             s_axis_tready,
    output logic signed [DATA_OUT_WIDTH-1:0] m_axis_tdata,
    output logic                             m_axis_tvalid,
    output logic                             m_axis_tlast,
    output logic                             m_axis_tuser,
    input  logic                             m_axis_tready,
    input  logic                             coef_wr_en,
    input  logic [ADDR_WIDTH-1:0]            coef_wr_addr,
    input  logic signed [TAP_WIDTH-1:0]      coef_wr_data,
    input  logic                             coef_swap,
    output logic                             coef_swap_pending
);

    localparam int LEVELS     = $clog2(NUM_TAPS);
    localparam int PAD        = 1 << LEVELS;
    localparam int PROD_WIDTH = TAP_WIDTH + DATA_IN_WIDTH;

    logic signed [TAP_WIDTH-1:0]      shadow_r [NUM_TAPS];
    logic signed [TAP_WIDTH-1:0]      active_r [NUM_TAPS];
    logic                             pending_r;
    logic [NUM_TAPS-1:0]              wr_hit_s;

    logic signed [DATA_IN_WIDTH-1:0]  dl_r [NUM_TAPS];
    logic                             dl_valid_r;
    logic                             dl_last_r;
    logic                             first_r;

    logic signed [ACC_WIDTH-1:0]      sum_r [LEVELS+1][PAD];
    logic [LEVELS:0]                  sum_valid_r;
    logic [LEVELS:0]                  sum_last_r;

    logic signed [ACC_WIDTH-1:0]      acc_s;
    logic signed [DATA_OUT_WIDTH-1:0] narrow_s;
    logic                             ovf_s;

    logic signed [DATA_OUT_WIDTH-1:0] out_data_r;
    logic                             out_valid_r;
    logic                             out_last_r;
    logic                             out_user_r;

    logic signed [DATA_OUT_WIDTH-1:0] skid_data_r;
    logic                             skid_valid_r;
    logic                             skid_last_r;
    logic                             skid_user_r;
    logic                             skid_load_s;
    logic                             skid_next_s;
    logic                             ready_r;

    logic                             adv_s;
    logic                             accept_s;
    logic                             apply_swap_s;

    function automatic logic signed [ACC_WIDTH-1:0] mul_ext(
        input logic signed [TAP_WIDTH-1:0]     c,
        input logic signed [DATA_IN_WIDTH-1:0] x
    );
        logic signed [PROD_WIDTH-1:0] p;
        p = PROD_WIDTH'(c) * PROD_WIDTH'(x);
        return ACC_WIDTH'(p);
    endfunction

    // ready_r mirrors !skid_valid_r but stays low through reset and the first edge after it
    assign adv_s             = ready_r;
    assign accept_s          = s_axis_tvalid && adv_s;
    assign apply_swap_s      = accept_s && first_r && pending_r;
    assign s_axis_tready     = ready_r;
    assign coef_swap_pending = pending_r;

    // Decode which shadow tap a write targets; out-of-range addresses hit nothing
    always_comb begin
        wr_hit_s = '0;
        for (int j = 0; j < NUM_TAPS; j++) begin
            if (coef_wr_en && (coef_wr_addr == ADDR_WIDTH'(j))) begin
                wr_hit_s[j] = 1'b1;
            end else begin
                wr_hit_s[j] = 1'b0;
            end
        end
    end

    // Shadow/active coefficient banks and the pending-swap flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NUM_TAPS; j++) begin
                shadow_r[j] <= '0;
                active_r[j] <= '0;
            end
            shadow_r[0] <= TAP_WIDTH'(1'b1);
            active_r[0] <= TAP_WIDTH'(1'b1);
            pending_r   <= 1'b0;
        end else begin
            for (int j = 0; j < NUM_TAPS; j++) begin
                if (wr_hit_s[j]) begin
                    shadow_r[j] <= coef_wr_data;
                end
                // a write landing on the swap edge is part of the new bank
                if (apply_swap_s) begin
                    active_r[j] <= wr_hit_s[j] ? coef_wr_data : shadow_r[j];
                end
            end
            if (coef_swap) begin
                pending_r <= 1'b1;
            end else if (apply_swap_s) begin
                pending_r <= 1'b0;
            end
        end
    end

    // Delay line: shift on accept, zero the history on the first sample of a packet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NUM_TAPS; j++) begin
                dl_r[j] <= '0;
            end
            dl_valid_r <= 1'b0;
            dl_last_r  <= 1'b0;
            first_r    <= 1'b1;
        end else begin
            if (accept_s) begin
                dl_r[0] <= s_axis_tdata;
                for (int j = 1; j < NUM_TAPS; j++) begin
                    dl_r[j] <= first_r ? '0 : dl_r[j-1];
                end
                first_r <= s_axis_tlast;
            end
            if (adv_s) begin
                dl_valid_r <= accept_s;
                dl_last_r  <= accept_s && s_axis_tlast;
            end
        end
    end

    // Product stage (level 0) followed by the registered adder-tree levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l <= LEVELS; l++) begin
                for (int j = 0; j < PAD; j++) begin
                    sum_r[l][j] <= '0;
                end
            end
            sum_valid_r <= '0;
            sum_last_r  <= '0;
        end else if (adv_s) begin
            for (int j = 0; j < NUM_TAPS; j++) begin
                sum_r[0][j] <= mul_ext(active_r[j], dl_r[j]);
            end
            for (int l = 1; l <= LEVELS; l++) begin
                for (int j = 0; j < (PAD >> l); j++) begin
                    sum_r[l][j] <= sum_r[l-1][2*j] + sum_r[l-1][2*j+1];
                end
            end
            sum_valid_r[0] <= dl_valid_r;
            sum_last_r[0]  <= dl_last_r;
            for (int l = 1; l <= LEVELS; l++) begin
                sum_valid_r[l] <= sum_valid_r[l-1];
                sum_last_r[l]  <= sum_last_r[l-1];
            end
        end else begin
            sum_valid_r <= sum_valid_r;
        end
    end

    assign acc_s = sum_r[LEVELS][0];

    generate
        if (DATA_OUT_WIDTH >= ACC_WIDTH) begin : g_wide
            assign narrow_s = DATA_OUT_WIDTH'(acc_s);
            assign ovf_s    = 1'b0;
        end else begin : g_narrow
            localparam logic [DATA_OUT_WIDTH-1:0] OUT_MAX = {DATA_OUT_WIDTH{1'b1}} >> 1;
            localparam logic [DATA_OUT_WIDTH-1:0] OUT_MIN = ~OUT_MAX;
            logic [ACC_WIDTH-DATA_OUT_WIDTH:0] upper_s;
            assign upper_s = acc_s[ACC_WIDTH-1:DATA_OUT_WIDTH-1];
            // representable only when every dropped bit equals the new sign bit
            assign ovf_s   = !((&upper_s) || !(|upper_s));
`ifdef AXIS_FIR_PROG_SAT_EN
            assign narrow_s = !ovf_s ? acc_s[DATA_OUT_WIDTH-1:0]
                                     : (acc_s[ACC_WIDTH-1] ? OUT_MIN : OUT_MAX);
`else
            assign narrow_s = acc_s[DATA_OUT_WIDTH-1:0];
`endif
        end
    endgenerate

    // Output register, advancing with the rest of the pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_user_r  <= 1'b0;
        end else if (adv_s) begin
            out_data_r  <= narrow_s;
            out_valid_r <= sum_valid_r[LEVELS];
            out_last_r  <= sum_last_r[LEVELS];
            out_user_r  <= ovf_s && sum_valid_r[LEVELS];
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Skid next-state: fill when the output stalls, drain once downstream takes it
    always_comb begin
        skid_load_s = out_valid_r && !skid_valid_r && !m_axis_tready;
        if (skid_valid_r) begin
            skid_next_s = !m_axis_tready;
        end else begin
            skid_next_s = skid_load_s;
        end
    end

    // Skid register and the registered input-ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_data_r  <= '0;
            skid_valid_r <= 1'b0;
            skid_last_r  <= 1'b0;
            skid_user_r  <= 1'b0;
            ready_r      <= 1'b0;
        end else begin
            skid_valid_r <= skid_next_s;
            ready_r      <= !skid_next_s;
            if (skid_load_s) begin
                skid_data_r <= out_data_r;
                skid_last_r <= out_last_r;
                skid_user_r <= out_user_r;
            end
        end
    end

    // Master port presents the skid first, otherwise the output register
    always_comb begin
        if (skid_valid_r) begin
            m_axis_tdata = skid_data_r;
            m_axis_tlast = skid_last_r;
            m_axis_tuser = skid_user_r;
        end else begin
            m_axis_tdata = out_data_r;
            m_axis_tlast = out_last_r;
            m_axis_tuser = out_user_r;
        end
    end

    assign m_axis_tvalid = skid_valid_r || out_valid_r;

endmodule

// File: tb/tb_axis_fir_prog.sv
// Directed bench for axis_fir_prog: a 4-tap full-width instance and a 12-bit-output instance share stimulus.
module tb_axis_fir_prog;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [7:0]  s_tdata = '0;
    logic               s_tvalid = 1'b0;
    logic               s_tlast = 1'b0;
    logic               s_tready, n_tready;
    logic signed [17:0] m_tdata;
    logic               m_tvalid, m_tlast, m_tuser;
    logic signed [11:0] n_tdata;
    logic               n_tvalid, n_tlast, n_tuser;
    logic               m_tready = 1'b1;
    logic               coef_wr_en = 1'b0;
    logic [1:0]         coef_wr_addr = '0;
    logic signed [7:0]  coef_wr_data = '0;
    logic               coef_swap = 1'b0;
    logic               pending, n_pending;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        int   d;
        logic l;
        logic u;
        int   nd;
        logic nv;
        logic nl;
        logic nu;
    } beat_t;
    beat_t q[$];

    axis_fir_prog #(.NUM_TAPS(4), .TAP_WIDTH(8), .DATA_IN_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
        .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
        .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
        .coef_swap(coef_swap), .coef_swap_pending(pending)
    );

    axis_fir_prog #(.NUM_TAPS(4), .TAP_WIDTH(8), .DATA_IN_WIDTH(8), .DATA_OUT_WIDTH(12)) dut_n (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(n_tready),
        .m_axis_tdata(n_tdata), .m_axis_tvalid(n_tvalid), .m_axis_tlast(n_tlast),
        .m_axis_tuser(n_tuser), .m_axis_tready(m_tready),
        .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
        .coef_swap(coef_swap), .coef_swap_pending(n_pending)
    );

    always #5 clk = ~clk;

    // Record every beat the consumer takes; values are stable from here to the next rising edge
    always @(negedge clk) begin
        if (rst_n && m_tvalid && m_tready) begin
            q.push_back('{int'(m_tdata), m_tlast, m_tuser, int'(n_tdata), n_tvalid, n_tlast, n_tuser});
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int d, input logic l);
        logic acc;
        int   t;
        t = 0;
        s_tvalid = 1'b1;
        s_tdata  = 8'(d);
        s_tlast  = l;
        do begin
            acc = s_tready;
            step(1);
            t++;
        end while (!acc && t < 100);
        if (!acc) chk("send_timeout", 32'(acc), 32'sd1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wr_coefs(input int c0, input int c1, input int c2, input int c3, input logic swap);
        int cs[4];
        cs = '{c0, c1, c2, c3};
        for (int i = 0; i < 4; i++) begin
            coef_wr_en   = 1'b1;
            coef_wr_addr = 2'(i);
            coef_wr_data = 8'(cs[i]);
            step(1);
        end
        coef_wr_en = 1'b0;
        if (swap) begin
            coef_swap = 1'b1;
            step(1);
            coef_swap = 1'b0;
        end
    endtask

    task automatic pop_chk(input string tag, input int ed, input logic el, input int en, input logic eu);
        beat_t b;
        int    t;
        t = 0;
        while (q.size() == 0 && t < 100) begin
            step(1);
            t++;
        end
        if (q.size() == 0) begin
            chk({tag, "_timeout"}, q.size(), 32'sd1);
        end else begin
            b = q.pop_front();
            chk({tag, "_data"}, b.d, ed);
            chk({tag, "_last"}, 32'(b.l), 32'(el));
            chk({tag, "_user"}, 32'(b.u), 32'sd0);
            chk({tag, "_n_data"}, b.nd, en);
            chk({tag, "_n_user"}, 32'(b.nu), 32'(eu));
            chk({tag, "_n_vl"}, 32'({b.nv, b.nl}), 32'({1'b1, el}));
        end
    endtask

    task automatic pop(input string tag, input int ed, input logic el);
        pop_chk(tag, ed, el, ed, 1'b0);
    endtask

    initial begin
        int   sent;
        logic pre;
        logic acc;
        int   nexp[4];

        // Reset state
        step(2);
        chk("rst_tready", 32'(s_tready), 32'sd0);
        chk("rst_mvalid", 32'(m_tvalid), 32'sd0);
        chk("rst_mdata", m_tdata, 32'sd0);
        chk("rst_last_user", 32'({m_tlast, m_tuser}), 32'sd0);
        chk("rst_pending", 32'({pending, n_pending, n_tready}), 32'sd0);
        #2 rst_n = 1'b1;
        step(1);
        chk("rel_tready", 32'(s_tready), 32'sd1);

        // 1: identity pass-through, latency and tlast placement
        s_tvalid = 1'b1; s_tdata = 8'sd5; s_tlast = 1'b0;
        step(1);
        s_tdata = -8'sd3;
        step(1);
        s_tdata = 8'sd7; s_tlast = 1'b1;
        step(1);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        step(1);
        chk("t1_lat_early", 32'(m_tvalid), 32'sd0);
        step(1);
        chk("t1_lat_valid", 32'(m_tvalid), 32'sd1);
        chk("t1_lat_data", m_tdata, 32'sd5);
        pop("t1_y0", 5, 1'b0);
        pop("t1_y1", -3, 1'b0);
        pop("t1_y2", 7, 1'b1);
        step(3);
        chk("t1_extra", q.size(), 32'sd0);

        // 2: programmed coefficients, impulse response, history cleared between packets
        wr_coefs(1, 2, 3, 4, 1'b1);
        chk("t2_pending_set", 32'(pending), 32'sd1);
        for (int p = 0; p < 2; p++) begin
            send(1, 1'b0);
            chk("t2_pending_clr", 32'(pending), 32'sd0);
            send(0, 1'b0); send(0, 1'b0); send(0, 1'b0); send(0, 1'b1);
            pop("t2_y0", 1, 1'b0);
            pop("t2_y1", 2, 1'b0);
            pop("t2_y2", 3, 1'b0);
            pop("t2_y3", 4, 1'b0);
            pop("t2_y4", 0, 1'b1);
        end
        step(3);
        chk("t2_extra", q.size(), 32'sd0);

        // 3: swap requested mid-packet waits for the next packet
        wr_coefs(1, 1, 1, 1, 1'b1);
        send(1, 1'b0); send(1, 1'b0);
        wr_coefs(2, 2, 2, 2, 1'b1);
        send(1, 1'b0); send(1, 1'b0); send(1, 1'b0); send(1, 1'b1);
        pop("t3_y0", 1, 1'b0);
        pop("t3_y1", 2, 1'b0);
        pop("t3_y2", 3, 1'b0);
        pop("t3_y3", 4, 1'b0);
        pop("t3_y4", 4, 1'b0);
        pop("t3_y5", 4, 1'b1);
        chk("t3_pending_held", 32'(pending), 32'sd1);
        send(1, 1'b1);
        chk("t3_pending_clr", 32'(pending), 32'sd0);
        pop("t3_next", 2, 1'b1);
        step(3);
        chk("t3_extra", q.size(), 32'sd0);

        // 4: continuous stream with backpressure windows; y = x[n] + 2*x[n-3]
        wr_coefs(1, 0, 0, 2, 1'b1);
        sent = 0;
        for (int c = 0; c < 60; c++) begin
            m_tready = !((c >= 6 && c <= 8) || (c >= 13 && c <= 15) || (c >= 22 && c <= 24));
            if (sent < 20) begin
                s_tvalid = 1'b1;
                s_tdata  = 8'(sent + 1);
                s_tlast  = (sent == 19);
            end else begin
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
            end
            pre = m_tvalid && !m_tready && s_tready;
            acc = s_tready && s_tvalid;
            step(1);
            if (acc) sent++;
            if (pre) chk("t4_tready_drop", 32'(s_tready), 32'sd0);
        end
        s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
        chk("t4_sent", sent, 32'sd20);
        for (int i = 0; i < 20; i++) begin
            pop("t4_y", (i + 1) + ((i >= 3) ? 2 * (i - 2) : 0), (i == 19));
        end
        step(3);
        chk("t4_extra", q.size(), 32'sd0);

        // 5: narrow output instance overflows; a write on the swap edge joins the new bank
`ifdef AXIS_FIR_PROG_SAT_EN
        nexp = '{2047, 2047, 2047, 2047};
`else
        nexp = '{-255, -510, -765, -1020};
`endif
        wr_coefs(127, 127, 127, 0, 1'b1);
        coef_wr_en = 1'b1; coef_wr_addr = 2'd3; coef_wr_data = 8'sd127;
        send(127, 1'b0);
        coef_wr_en = 1'b0;
        send(127, 1'b0); send(127, 1'b0); send(127, 1'b1);
        pop_chk("t5_y0", 16129, 1'b0, nexp[0], 1'b1);
        pop_chk("t5_y1", 32258, 1'b0, nexp[1], 1'b1);
        pop_chk("t5_y2", 48387, 1'b0, nexp[2], 1'b1);
        pop_chk("t5_y3", 64516, 1'b1, nexp[3], 1'b1);
        chk("t5_n_side", 32'({n_tready, n_pending}), 32'({s_tready, pending}));
        step(3);
        chk("t5_extra", q.size(), 32'sd0);

        // 6: asynchronous reset mid-packet, then a clean packet with identity coefficients
        send(1, 1'b0); send(2, 1'b0); send(3, 1'b0);
        coef_swap = 1'b1;
        step(1);
        coef_swap = 1'b0;
        step(1);
        chk("t6_pre_valid", 32'(m_tvalid), 32'sd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(m_tvalid), 32'sd0);
        chk("t6_rst_data", m_tdata, 32'sd0);
        chk("t6_rst_flags", 32'({m_tlast, m_tuser, s_tready, pending}), 32'sd0);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        send(2, 1'b0); send(0, 1'b1);
        pop("t6_y0", 2, 1'b0);
        pop("t6_y1", 0, 1'b1);
        step(3);
        chk("t6_extra", q.size(), 32'sd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
